// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath.
// Optional JALR support is compiled in when CTRL_JALR_EN is defined.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  result_src,
    output logic        fault,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_LUI    = 4'd11,
        S_JALR   = 4'd12,
        S_FAULT  = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       fetch;
        logic       branch;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] alu_ctrl;
        logic [1:0] result_src;
        logic       fault;
    } ctrl_t;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    state_t                state;
    state_t                state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
    ctrl_t                 ctrl_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        logic [2:0] op;
        op = 3'b000;
        case (f3)
            3'b000:  op = sub ? 3'b001 : 3'b000;
            3'b100:  op = 3'b100;
            3'b110:  op = 3'b011;
            3'b111:  op = 3'b010;
            3'b010:  op = 3'b101;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
               (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Moore decode of a state; instr is stable from DECODE onward because IR only loads in FETCH
    function automatic ctrl_t decode(input state_t s, input logic [31:0] ir);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 3'b010;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = ir[5] ? 3'b001 : 3'b000;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = 2'b01;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_ctrl  = alu_op(ir[14:12], ir[30]);
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_ctrl  = alu_op(ir[14:12], 1'b0);
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.imm_src   = 3'b010;
                c.alu_ctrl  = 3'b001;
                c.branch    = (ir[14:13] == 2'b00);
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b01;
                c.imm_src    = 3'b011;
                c.result_src = 2'b10;
            end
            S_JALR: begin
                c.pc_write   = 1'b1;
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
                c.imm_src   = 3'b100;
            end
            S_FAULT: begin
                c.fault = 1'b1;
            end
            default: begin
                c.fault = 1'b1;
            end
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            S_FETCH:  if (ctrl_q.mem_req && mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
                    7'b0110011:             state_nxt = S_EXECR;
                    7'b0010011:             state_nxt = S_EXECI;
                    7'b1100011:             state_nxt = S_BRANCH;
                    7'b1101111:             state_nxt = S_JAL;
                    7'b0110111:             state_nxt = S_LUI;
`ifdef CTRL_JALR_EN
                    7'b1100111:             state_nxt = (funct3 == 3'b000) ? S_JALR : S_FAULT;
`endif
                    default:                state_nxt = S_FAULT;
                endcase
            end
            S_MEMADR: state_nxt = opcode[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_EXECR,
            S_EXECI:  state_nxt = f3_supported(funct3) ? S_ALUWB : S_FAULT;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = (funct3[2:1] == 2'b00) ? S_FETCH : S_FAULT;
            S_JAL,
            S_JALR,
            S_LUI:    state_nxt = S_ALUWB;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_FAULT;
        endcase

        // Any non-waiting cycle leaves the counter at zero, so each memory state starts fresh
        if (ctrl_q.mem_req && !mem_ready) begin
            if (wait_cnt == WAIT_LAST) begin
                state_nxt = S_FAULT;
            end else begin
                wait_cnt_nxt = wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            ctrl_q   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            ctrl_q   <= decode(state_nxt, instr);
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign adr_src    = ctrl_q.adr_src;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign imm_src    = ctrl_q.imm_src;
    assign alu_ctrl   = ctrl_q.alu_ctrl;
    assign result_src = ctrl_q.result_src;
    assign fault      = ctrl_q.fault;
    assign state_dbg  = state;

    // IR and PC strobes in FETCH only fire on the handshake; branch PC update follows the comparison
    assign ir_write = ctrl_q.fetch & mem_ready;
    assign pc_write = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready) |
                      (ctrl_q.branch & (eq ^ instr[12]));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_WAIT_MAX = 4); JALR checks follow CTRL_JALR_EN.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  imm_src;
    logic [2:0]  alu_ctrl;
    logic [1:0]  result_src;
    logic        fault;
    logic [3:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3;
    localparam logic [3:0] MEMWB = 4'd4, MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7;
    localparam logic [3:0] ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, LUI = 4'd11;
    localparam logic [3:0] JALR = 4'd12, FLT = 4'd15;

    multicycle_control #(.MEM_WAIT_MAX(4), .WAIT_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .fault(fault), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'b0, f3, 5'b0, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Completes a FETCH handshake with the given IR contents and lands in DECODE
    task automatic fetch_instr(input logic [31:0] ir);
        instr     = ir;
        mem_ready = 1'b1;
        #1;
        chk("fetch_state", 32'(state_dbg), 32'(FETCH));
        chk("fetch_ir_write", 32'(ir_write), 32'd1);
        chk("fetch_pc_write", 32'(pc_write), 32'd1);
        chk("fetch_src_b", 32'(alu_src_b), 32'd2);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("decode_state", 32'(state_dbg), 32'(DECODE));
        chk("decode_ir_write", 32'(ir_write), 32'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state_dbg), 32'(FETCH));
        chk("rst_fault", 32'(fault), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_exit_mem_req", 32'(mem_req), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h0000_0013; eq = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", 32'(state_dbg), 32'(FETCH));
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_reg_write", 32'(reg_write), 32'd0);
        chk("reset_src_b", 32'(alu_src_b), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("fetch_mem_req", 32'(mem_req), 32'd1);
        chk("fetch_adr_src", 32'(adr_src), 32'd0);

        // lw
        fetch_instr(mk(7'd0, 3'b010, 7'b0000011));
        chk("decode_src_a", 32'(alu_src_a), 32'd1);
        chk("decode_imm", 32'(imm_src), 32'd2);
        tick();
        chk("lw_memadr", 32'(state_dbg), 32'(MEMADR));
        chk("lw_imm_i", 32'(imm_src), 32'd0);
        tick();
        chk("lw_memrd", 32'(state_dbg), 32'(MEMRD));
        chk("lw_adr_src", 32'(adr_src), 32'd1);
        chk("lw_mem_we", 32'(mem_we), 32'd0);
        chk("lw_no_rw_rd", 32'(reg_write), 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("lw_memwb", 32'(state_dbg), 32'(MEMWB));
        chk("lw_reg_write", 32'(reg_write), 32'd1);
        chk("lw_result_src", 32'(result_src), 32'd1);
        tick();
        chk("lw_back_fetch", 32'(state_dbg), 32'(FETCH));
        chk("lw_rw_off", 32'(reg_write), 32'd0);

        // sw, ready arrives on the last permitted wait cycle
        fetch_instr(mk(7'd0, 3'b010, 7'b0100011));
        tick();
        chk("sw_imm_s", 32'(imm_src), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk("sw_memwr", 32'(state_dbg), 32'(MEMWR));
            chk("sw_mem_we", 32'(mem_we), 32'd1);
            chk("sw_no_rw", 32'(reg_write), 32'd0);
            tick();
        end
        mem_ready = 1'b0;
        chk("sw_back_fetch", 32'(state_dbg), 32'(FETCH));
        chk("sw_no_fault", 32'(fault), 32'd0);

        // R-type sub, then identical fields as I-type
        fetch_instr(mk(7'b0100000, 3'b000, 7'b0110011));
        tick();
        chk("sub_state", 32'(state_dbg), 32'(EXECR));
        chk("sub_alu", 32'(alu_ctrl), 32'd1);
        chk("sub_src_b", 32'(alu_src_b), 32'd0);
        tick();
        chk("sub_aluwb", 32'(state_dbg), 32'(ALUWB));
        chk("sub_reg_write", 32'(reg_write), 32'd1);
        tick();
        fetch_instr(mk(7'b0100000, 3'b000, 7'b0010011));
        tick();
        chk("addi_state", 32'(state_dbg), 32'(EXECI));
        chk("addi_alu", 32'(alu_ctrl), 32'd0);
        chk("addi_src_b", 32'(alu_src_b), 32'd1);
        tick();
        tick();
        fetch_instr(mk(7'd0, 3'b100, 7'b0110011));
        tick();
        chk("xor_alu", 32'(alu_ctrl), 32'd4);
        tick();
        tick();
        fetch_instr(mk(7'd0, 3'b111, 7'b0010011));
        tick();
        chk("andi_alu", 32'(alu_ctrl), 32'd2);
        tick();
        tick();

        // bne and beq against both eq values
        fetch_instr(mk(7'd0, 3'b001, 7'b1100011));
        tick();
        chk("bne_state", 32'(state_dbg), 32'(BRANCH));
        chk("bne_alu", 32'(alu_ctrl), 32'd1);
        eq = 1'b1; #1;
        chk("bne_eq1", 32'(pc_write), 32'd0);
        eq = 1'b0; #1;
        chk("bne_eq0", 32'(pc_write), 32'd1);
        tick();
        chk("bne_fetch", 32'(state_dbg), 32'(FETCH));
        fetch_instr(mk(7'd0, 3'b000, 7'b1100011));
        tick();
        eq = 1'b1; #1;
        chk("beq_eq1", 32'(pc_write), 32'd1);
        eq = 1'b0; #1;
        chk("beq_eq0", 32'(pc_write), 32'd0);
        tick();

        // jal and lui
        fetch_instr(mk(7'd0, 3'b000, 7'b1101111));
        tick();
        chk("jal_state", 32'(state_dbg), 32'(JAL));
        chk("jal_pc_write", 32'(pc_write), 32'd1);
        chk("jal_imm", 32'(imm_src), 32'd3);
        chk("jal_no_rw", 32'(reg_write), 32'd0);
        tick();
        chk("jal_aluwb_rw", 32'(reg_write), 32'd1);
        chk("jal_aluwb_pc", 32'(pc_write), 32'd0);
        tick();
        fetch_instr(mk(7'd0, 3'b000, 7'b0110111));
        tick();
        chk("lui_state", 32'(state_dbg), 32'(LUI));
        chk("lui_src_a", 32'(alu_src_a), 32'd3);
        chk("lui_imm", 32'(imm_src), 32'd4);
        tick();
        chk("lui_aluwb", 32'(state_dbg), 32'(ALUWB));
        tick();

        // FETCH timeout with mem_ready held low
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_state", 32'(state_dbg), 32'(FETCH));
            chk("to_wait_fault", 32'(fault), 32'd0);
            tick();
        end
        chk("to_fault_state", 32'(state_dbg), 32'(FLT));
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("to_sticky", 32'(fault), 32'd1);
        chk("to_no_ir_write", 32'(ir_write), 32'd0);
        chk("to_no_pc_write", 32'(pc_write), 32'd0);
        mem_ready = 1'b0;
        reset_pulse();

        // illegal opcode and unsupported funct3
        fetch_instr(mk(7'd0, 3'b000, 7'b1110011));
        tick();
        chk("ill_op_fault", 32'(fault), 32'd1);
        chk("ill_op_state", 32'(state_dbg), 32'(FLT));
        reset_pulse();
        fetch_instr(mk(7'd0, 3'b001, 7'b0110011));
        tick();
        tick();
        chk("ill_f3_fault", 32'(fault), 32'd1);
        chk("ill_f3_no_rw", 32'(reg_write), 32'd0);
        reset_pulse();

        // 1100111 decodes to JALR only when enabled
        fetch_instr(mk(7'd0, 3'b000, 7'b1100111));
        tick();
`ifdef CTRL_JALR_EN
        chk("jalr_state", 32'(state_dbg), 32'(JALR));
        chk("jalr_pc_write", 32'(pc_write), 32'd1);
        chk("jalr_src_a", 32'(alu_src_a), 32'd2);
        tick();
        chk("jalr_aluwb_rw", 32'(reg_write), 32'd1);
        tick();
        chk("jalr_fetch", 32'(state_dbg), 32'(FETCH));
`else
        chk("jalr_off_state", 32'(state_dbg), 32'(FLT));
        chk("jalr_off_fault", 32'(fault), 32'd1);
        reset_pulse();
`endif

        // reset during MEMWB drops the register write immediately
        fetch_instr(mk(7'd0, 3'b010, 7'b0000011));
        tick();
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("abort_rw_before", 32'(reg_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rw_after", 32'(reg_write), 32'd0);
        chk("abort_state", 32'(state_dbg), 32'(FETCH));
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
